// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS hex display: mode encoding,
// maximal-length LFSR tap masks and active-low seven-segment glyphs.
package prbs_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_STEP = 2'd1,
    MODE_FREE = 2'd2
  } mode_e;

  // Tap masks for next = {state[W-2:0], ^(state & mask)}, bit i = state[i].
  function automatic logic [15:0] tap_mask(input int unsigned width);
    logic [15:0] mask;
    case (width)
      3:       mask = 16'h0006;
      4:       mask = 16'h000C;
      5:       mask = 16'h0014;
      6:       mask = 16'h0030;
      7:       mask = 16'h0060;
      8:       mask = 16'h00B8;
      9:       mask = 16'h0110;
      10:      mask = 16'h0240;
      11:      mask = 16'h0500;
      12:      mask = 16'h0829;
      13:      mask = 16'h100D;
      14:      mask = 16'h2015;
      15:      mask = 16'h6000;
      16:      mask = 16'hD008;
      default: mask = 16'h0000;
    endcase
    return mask;
  endfunction

  // Active-low glyphs, bit order g..a.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/prbs_hex_display_seg7_hex_decoder.sv
// Combinational 4-bit to active-low seven-segment hex decoder.
module seg7_hex_decoder
  import prbs_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_GLYPH[i_nibble];
  end

endmodule

// File: rtl/prbs_hex_display.sv
// Maximal-length Fibonacci LFSR with hold / step / free-run advance and a
// registered active-low hex readout across N_DIGITS seven-segment digits.
module prbs_hex_display
  import prbs_pkg::*;
#(
  parameter  int unsigned WIDTH      = 7,
  parameter  int unsigned RESET_SEED = 1,
  parameter  int unsigned TICK_DIV   = 50_000_000,
  localparam int unsigned N_DIGITS   = (WIDTH + 3) / 4
) (
  input  logic                  i_clk,
  input  logic                  i_srst,
  input  logic [1:0]            i_mode,
  input  logic                  i_step,
  input  logic                  i_seedLoad,
  input  logic [WIDTH-1:0]      i_seed,
  output logic [WIDTH-1:0]      o_value,
  output logic                  o_advance,
  output logic [7*N_DIGITS-1:0] o_segments
);

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("prbs_hex_display: WIDTH must be within 3..16");
  end
  if (WIDTH'(RESET_SEED) == '0) begin : g_bad_seed
    $error("prbs_hex_display: RESET_SEED must be nonzero");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("prbs_hex_display: TICK_DIV must be at least 1");
  end

  localparam int unsigned     PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] TAP       = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] SEED_RST  = WIDTH'(RESET_SEED);
  localparam logic [WIDTH-1:0] SEED_ONE  = WIDTH'(1);

  logic [WIDTH-1:0]      value_q, value_d;
  logic                  adv_q, adv_d;
  logic [7*N_DIGITS-1:0] seg_q, seg_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  step_q, step_d;
  logic                  tick, advance;
  logic [4*N_DIGITS-1:0] padded;

  always_comb begin
    padded             = '0;
    padded[WIDTH-1:0]  = value_q;
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    seg7_hex_decoder u_dec (
      .i_nibble (padded[4*k +: 4]),
      .o_seg    (seg_d[7*k +: 7])
    );
  end

  // Prescaler only runs in FREE, so leaving or entering FREE restarts it at 0.
  always_comb begin
    step_d  = i_step;
    presc_d = '0;
    tick    = 1'b0;
    if (i_mode == MODE_FREE) begin
      if (presc_q == PRESC_LAST) tick = 1'b1;
      else                       presc_d = presc_q + PW'(1);
    end
    advance = tick || (i_mode == MODE_STEP && i_step && !step_q);

    value_d = value_q;
    adv_d   = 1'b0;
    if (i_seedLoad) begin
      value_d = (i_seed == '0) ? SEED_ONE : i_seed;
    end else if (advance) begin
      value_d = {value_q[WIDTH-2:0], ^(value_q & TAP)};
      adv_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      value_q <= SEED_RST;
      adv_q   <= 1'b0;
      seg_q   <= '1;
      presc_q <= '0;
      step_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      adv_q   <= adv_d;
      seg_q   <= seg_d;
      presc_q <= presc_d;
      step_q  <= step_d;
    end
  end

  assign o_value    = value_q;
  assign o_advance  = adv_q;
  assign o_segments = seg_q;

endmodule

// File: tb/tb_prbs_hex_display.sv
// Bench for prbs_hex_display: cycle scoreboard on a WIDTH=7 instance plus
// full-period runs on WIDTH=3 and WIDTH=16 instances.
module tb_prbs_hex_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  localparam logic [6:0] GLY [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // ---------------- WIDTH=7, TICK_DIV=4 ----------------
  logic       srst7 = 1'b1, step7 = 1'b0, load7 = 1'b0;
  logic [1:0] mode7 = 2'd0;
  logic [6:0] seed7 = '0;
  logic [6:0] val7;
  logic       adv7;
  logic [13:0] seg7;

  prbs_hex_display #(.WIDTH(7), .RESET_SEED(1), .TICK_DIV(4)) u7 (
    .i_clk(clk), .i_srst(srst7), .i_mode(mode7), .i_step(step7),
    .i_seedLoad(load7), .i_seed(seed7),
    .o_value(val7), .o_advance(adv7), .o_segments(seg7)
  );

  // ---------------- WIDTH=3, TICK_DIV=2 ----------------
  logic       srst3 = 1'b1;
  logic [1:0] mode3 = 2'd0;
  logic [2:0] val3;
  logic       adv3;
  logic [6:0] seg3;

  prbs_hex_display #(.WIDTH(3), .RESET_SEED(5), .TICK_DIV(2)) u3 (
    .i_clk(clk), .i_srst(srst3), .i_mode(mode3), .i_step(1'b0),
    .i_seedLoad(1'b0), .i_seed(3'd0),
    .o_value(val3), .o_advance(adv3), .o_segments(seg3)
  );

  // ---------------- WIDTH=16, TICK_DIV=1 ----------------
  logic        srst16 = 1'b1;
  logic [1:0]  mode16 = 2'd0;
  logic [15:0] val16;
  logic        adv16;
  logic [27:0] seg16;

  prbs_hex_display #(.WIDTH(16), .RESET_SEED(16'hACE1), .TICK_DIV(1)) u16 (
    .i_clk(clk), .i_srst(srst16), .i_mode(mode16), .i_step(1'b0),
    .i_seedLoad(1'b0), .i_seed(16'd0),
    .o_value(val16), .o_advance(adv16), .o_segments(seg16)
  );

  // ---------------- scoreboard for u7 ----------------
  typedef struct {
    logic [6:0]  v;
    logic        a;
    logic [13:0] s;
  } exp_t;
  exp_t sb[$];

  logic [6:0]  m_val = '0;
  logic        m_step = 1'b0;
  int unsigned m_presc = 0;
  int unsigned n_adv = 0;
  int unsigned n_zero = 0;

  function automatic logic [13:0] seg_of7(input logic [6:0] v);
    logic [3:0] hi;
    hi = {1'b0, v[6:4]};
    return {GLY[hi], GLY[v[3:0]]};
  endfunction

  // Drive one cycle of inputs at the falling edge, push the model's
  // expectation, then compare at the next falling edge.
  task automatic drive7(input logic srst, input logic [1:0] mode, input logic step,
                        input logic load, input logic [6:0] seed);
    exp_t e;
    logic tick, edge_hit;
    srst7 = srst; mode7 = mode; step7 = step; load7 = load; seed7 = seed;
    if (srst) begin
      e.v = 7'h01; e.a = 1'b0; e.s = '1;
      m_step = 1'b0; m_presc = 0;
    end else begin
      e.s = seg_of7(m_val);
      tick = 1'b0;
      if (mode == 2'd2) begin
        if (m_presc == 3) begin tick = 1'b1; m_presc = 0; end
        else m_presc = m_presc + 1;
      end else m_presc = 0;
      edge_hit = (mode == 2'd1) && step && !m_step;
      m_step = step;
      if (load) begin
        e.v = (seed == 7'h00) ? 7'h01 : seed; e.a = 1'b0;
      end else if (tick || edge_hit) begin
        e.v = {m_val[5:0], m_val[6] ^ m_val[5]}; e.a = 1'b1;
      end else begin
        e.v = m_val; e.a = 1'b0;
      end
    end
    m_val = e.v;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("value", 32'(val7), 32'(e.v));
      check_eq("advance", 32'(adv7), 32'(e.a));
      check_eq("segments", 32'(seg7), 32'(e.s));
    end
    if (adv7) n_adv++;
    if (val7 == 7'h00) n_zero++;
  endtask

  localparam logic [6:0] STEP_SEQ [7] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};

  initial begin
    int unsigned a0, cnt, z;
    logic [15:0] prev16;

    @(negedge clk);
    srst3 = 1'b0; srst16 = 1'b0;

    // Reset and blank display
    drive7(1'b1, 2'd0, 1'b0, 1'b0, 7'h00);
    check_eq("rst_value", 32'(val7), 32'h01);
    check_eq("rst_seg", 32'(seg7), 32'h3FFF);
    drive7(1'b0, 2'd0, 1'b0, 1'b0, 7'h00);
    check_eq("seg_after_rst", 32'(seg7), 32'({7'b1000000, 7'b1111001}));

    // STEP pulses
    for (int i = 0; i < 7; i++) begin
      a0 = n_adv;
      drive7(1'b0, 2'd1, 1'b1, 1'b0, 7'h00);
      check_eq("step_seq", 32'(val7), 32'(STEP_SEQ[i]));
      drive7(1'b0, 2'd1, 1'b0, 1'b0, 7'h00);
      check_eq("step_pulses", n_adv - a0, 1);
    end

    // Held step gives one advance
    a0 = n_adv;
    for (int i = 0; i < 20; i++) drive7(1'b0, 2'd1, 1'b1, 1'b0, 7'h00);
    drive7(1'b0, 2'd1, 1'b0, 1'b0, 7'h00);
    check_eq("held_step", n_adv - a0, 1);
    check_eq("held_value", 32'(val7), 32'h06);

    // HOLD and mode 3 ignore pulses
    a0 = n_adv;
    for (int i = 0; i < 3; i++) begin
      drive7(1'b0, 2'd0, 1'b1, 1'b0, 7'h00);
      drive7(1'b0, 2'd3, 1'b0, 1'b0, 7'h00);
      drive7(1'b0, 2'd3, 1'b1, 1'b0, 7'h00);
      drive7(1'b0, 2'd0, 1'b0, 1'b0, 7'h00);
    end
    check_eq("hold_adv", n_adv - a0, 0);
    check_eq("hold_value", 32'(val7), 32'h06);

    // Full period in FREE
    a0 = n_adv; z = n_zero;
    for (int i = 0; i < 127 * 4; i++) drive7(1'b0, 2'd2, 1'b0, 1'b0, 7'h00);
    check_eq("free_period_adv", n_adv - a0, 127);
    check_eq("free_period_val", 32'(val7), 32'h06);
    check_eq("free_no_zero", n_zero - z, 0);

    // Zero seed guard
    drive7(1'b0, 2'd0, 1'b0, 1'b1, 7'h00);
    check_eq("seed0_guard", 32'(val7), 32'h01);

    // Load collides with a FREE tick
    for (int i = 0; i < 3; i++) drive7(1'b0, 2'd2, 1'b0, 1'b0, 7'h00);
    drive7(1'b0, 2'd2, 1'b0, 1'b1, 7'h55);
    check_eq("load_vs_tick_val", 32'(val7), 32'h55);
    check_eq("load_vs_tick_adv", 32'(adv7), 32'h0);

    // Reset mid-prescale
    for (int i = 0; i < 10; i++) drive7(1'b0, 2'd2, 1'b0, 1'b0, 7'h00);
    drive7(1'b1, 2'd2, 1'b1, 1'b1, 7'h7F);
    check_eq("midrst_value", 32'(val7), 32'h01);
    check_eq("midrst_adv", 32'(adv7), 32'h0);
    cnt = 0;
    do begin
      drive7(1'b0, 2'd2, 1'b0, 1'b0, 7'h00);
      cnt++;
    end while (!adv7 && cnt < 20);
    check_eq("midrst_first_tick", cnt, 4);
    drive7(1'b0, 2'd0, 1'b0, 1'b0, 7'h00);

    // WIDTH=3 full period
    check_eq("w3_rst", 32'(val3), 32'h5);
    mode3 = 2'd2;
    cnt = 0; z = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (adv3) cnt++;
      if (val3 == 3'd0) z++;
      if (cnt > 0 && val3 == 3'h5) break;
    end
    mode3 = 2'd0;
    check_eq("w3_period", cnt, 7);
    check_eq("w3_no_zero", z, 0);

    // WIDTH=16 full period, TICK_DIV=1
    check_eq("w16_rst", 32'(val16), 32'hACE1);
    mode16 = 2'd2;
    cnt = 0; z = 0; prev16 = val16;
    for (int i = 0; i < 70000; i++) begin
      prev16 = val16;
      @(negedge clk);
      if (adv16) cnt++;
      if (val16 == 16'd0) z++;
      if (cnt > 0 && val16 == 16'hACE1) break;
    end
    check_eq("w16_period", cnt, 65535);
    check_eq("w16_no_zero", z, 0);
    check_eq("w16_segments", 32'(seg16),
             32'({GLY[prev16[15:12]], GLY[prev16[11:8]], GLY[prev16[7:4]], GLY[prev16[3:0]]}));
    mode16 = 2'd0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
